dcache_wb_param: RTL
====================

Name: dcache_wb_param

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and the line-wide data memory.
- Replaces the event-driven read-only cache with a single-clock FSM.
- Adds:
  - dirty-line writeback
  - write hits and write misses
  - configurable line size and set count
  - hit/miss statistics counters

Parameters:
- ADDR_W, 32, byte address width
- WORD_W, 32, CPU data word width
- LINE_W, 256, cache line / memory transfer width in bits (power of two, multiple of WORD_W)
- NUM_SETS, 32, number of lines (power of two)
- CNT_W, 32, statistics counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- cpu_req_i  in  1  access valid this cycle
- cpu_we_i  in  1  1=store, 0=load
- cpu_addr_i  in  ADDR_W  byte address (word aligned)
- cpu_wdata_i  in  WORD_W  store data
- cpu_rdata_o  out  WORD_W  load data
- cpu_stall_o  out  1  freeze pipeline
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1=line write, 0=line read
- mem_addr_o  out  ADDR_W  line-aligned address
- mem_data_o  out  LINE_W  writeback line
- mem_data_i  in  LINE_W  refill line
- mem_ack_i  in  1  one-cycle completion pulse
- hit_cnt_o  out  CNT_W  completed hits
- miss_cnt_o  out  CNT_W  misses detected

Behaviour:
- Address split:
  - offset = low log2(LINE_W/8) bits
  - word select = offset bits above log2(WORD_W/8)
  - index = next log2(NUM_SETS) bits
  - tag = remainder
- Per set: valid, dirty, tag, LINE_W data.
- Reset (async):
  - all valid and dirty bits cleared; FSM enters IDLE
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0
  - hit/miss counters=0, cpu_rdata_o=0
  - Reset mid-transaction abandons it; mem_enable_o drops immediately; a late mem_ack_i after reset is ignored.
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE, hit (valid && tag match):
  - cpu_stall_o=0.
  - Load: cpu_rdata_o is the selected word, combinational, same cycle.
  - Store: word merged into the line at the clock edge; dirty set.
  - hit_cnt_o increments.
- IDLE, miss:
  - cpu_stall_o=1 combinationally in the request cycle; miss_cnt_o increments once.
  - Victim valid && dirty -> WRITEBACK; otherwise -> REFILL.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1
  - mem_addr_o = {victim tag, index, zeros}
  - mem_data_o = victim line
  - Hold until mem_ack_i, then -> REFILL.
- REFILL:
  - mem_enable_o=1, mem_write_o=0
  - mem_addr_o = {request tag, index, zeros}
  - On mem_ack_i: line := mem_data_i, tag updated, valid=1, dirty=0 -> IDLE.
- Replay: the request is re-evaluated in IDLE the cycle after refill, where it hits (hit_cnt_o increments; a store merges and sets dirty). cpu_stall_o stays 1 through WRITEBACK and REFILL and drops in the replay cycle.
- Latency:
  - hit: 0 stall cycles
  - clean miss: ack latency + 1
  - dirty miss: both ack latencies + 1
- CPU must hold req/we/addr/wdata stable while cpu_stall_o=1.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- mem_* outputs are registered and change only on state transitions.
- cpu_req_i=0 in IDLE: no state change, no counter change, stall 0.
- Counters wrap modulo 2^CNT_W.

Decomposition:
- Shared package dcache_pkg:
  - FSM state enum
  - derived widths: OFFSET_W, INDEX_W, TAG_W, WORDS_PER_LINE
  - helper function for line-aligned address build
- One sub-module: dcache_tag_data_array (valid/dirty/tag/data storage; async-reset valid/dirty; word-merge write port; full-line fill port).
- FSM, hit logic and counters live in the top.

Test Plan:
- Cold load to 0x0000_0040 after reset (mem returns line with word[0]=0xDEADBEEF, ack 4 cycles later):
  - WRITEBACK skipped; stall for 5 cycles; rdata=0xDEADBEEF
  - miss_cnt=1, hit_cnt=1
- Store 0x12345678 to 0x44 after the line is resident, then load 0x44:
  - zero stall; rdata=0x12345678; no mem_enable_o
  - line dirty; hit_cnt=3
- Load 0x0000_0440 (same index, different tag, victim dirty):
  - WRITEBACK first: mem_write_o=1, mem_addr_o=0x40, mem_data_o word[1]=0x12345678
  - then REFILL at 0x440
  - miss_cnt increments by 1
- Store miss to 0x0000_0840 with clean victim:
  - REFILL only, no writeback
  - after replay, line dirty and word[0]=store data
- rst_i asserted while in REFILL with mem_enable_o=1:
  - mem_enable_o=0 immediately; ack pulse 2 cycles later ignored
  - next load to 0x40 misses (valid cleared); counters restart from 0
- Back-to-back hits on all 8 words of one line, alternating load/store:
  - no stalls; counters advance by 8

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: FSM state type, derived-width helpers and the
// line-aligned address builder shared by the data cache files.
package dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_REFILL
  } state_e;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_WORD_W   = 32;
  localparam int DEF_LINE_W   = 256;
  localparam int DEF_NUM_SETS = 32;

  function automatic int calc_offset_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int calc_index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int calc_tag_w(input int addr_w,
                                    input int line_w,
                                    input int num_sets);
    return addr_w - calc_offset_w(line_w)
                  - calc_index_w(num_sets);
  endfunction

  function automatic int calc_wpl(input int line_w,
                                  input int word_w);
    return line_w / word_w;
  endfunction

  localparam int OFFSET_W = calc_offset_w(DEF_LINE_W);
  localparam int INDEX_W  = calc_index_w(DEF_NUM_SETS);
  localparam int TAG_W    = calc_tag_w(DEF_ADDR_W, DEF_LINE_W,
                                       DEF_NUM_SETS);
  localparam int WORDS_PER_LINE = calc_wpl(DEF_LINE_W,
                                           DEF_WORD_W);

  // {tag, index, zeros}; caller keeps the low ADDR_W bits
  function automatic logic [63:0] line_addr(
    input logic [63:0] tag,
    input logic [63:0] idx,
    input int          idx_w,
    input int          off_w
  );
    return (tag << (idx_w + off_w)) | (idx << off_w);
  endfunction

endpackage

// File: rtl/dcache_tag_data_array.sv
// dcache_tag_data_array: per-set valid/dirty/tag/line storage.
// Ports: idx_i read/write set; valid/dirty/tag/line read out
// combinationally; wr_* merges one word and sets dirty;
// fill_* loads a whole line, sets valid and clears dirty.
module dcache_tag_data_array
  import dcache_pkg::*;
#(
  parameter int LINE_W   = 256,
  parameter int WORD_W   = 32,
  parameter int NUM_SETS = 32,
  parameter int TAG_BITS = 22,
  parameter int IDX_BITS = 5,
  parameter int SEL_BITS = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IDX_BITS-1:0] idx_i,
  output logic                valid_o,
  output logic                dirty_o,
  output logic [TAG_BITS-1:0] tag_o,
  output logic [LINE_W-1:0]   line_o,
  input  logic                wr_en_i,
  input  logic [SEL_BITS-1:0] wr_sel_i,
  input  logic [WORD_W-1:0]   wr_data_i,
  input  logic                fill_en_i,
  input  logic [TAG_BITS-1:0] fill_tag_i,
  input  logic [LINE_W-1:0]   fill_line_i
);

  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [TAG_BITS-1:0] r_tag  [NUM_SETS];
  logic [LINE_W-1:0]   r_data [NUM_SETS];

  assign valid_o = r_valid[idx_i];
  assign dirty_o = r_dirty[idx_i];
  assign tag_o   = r_tag[idx_i];
  assign line_o  = r_data[idx_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (fill_en_i) begin
      r_valid[idx_i] <= 1'b1;
      r_dirty[idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      r_dirty[idx_i] <= 1'b1;
    end
  end

  // payload needs no reset: valid gates every use
  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      r_tag[idx_i]  <= fill_tag_i;
      r_data[idx_i] <= fill_line_i;
    end else if (wr_en_i) begin
      r_data[idx_i][wr_sel_i*WORD_W +: WORD_W] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dcache_wb_param.sv
// dcache_wb_param: direct-mapped write-back write-allocate cache.
// CPU side: req/we/addr/wdata in, rdata/stall out. Memory side:
// registered line requests, ack pulse. hit/miss counters out.
module dcache_wb_param
  import dcache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int WORD_W   = 32,
  parameter int LINE_W   = 256,
  parameter int NUM_SETS = 32,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_wdata_i,
  output logic [WORD_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int OFF_W = calc_offset_w(LINE_W);
  localparam int BYT_W = $clog2(WORD_W / 8);
  localparam int SEL_W = OFF_W - BYT_W;
  localparam int IDX_W = calc_index_w(NUM_SETS);
  localparam int TAG_B = calc_tag_w(ADDR_W, LINE_W, NUM_SETS);

  state_e r_state, w_state_n;

  logic              r_mem_en, w_mem_en_n;
  logic              r_mem_we, w_mem_we_n;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_n;
  logic [LINE_W-1:0] r_mem_data, w_mem_data_n;
  logic [CNT_W-1:0]  r_hit_cnt, r_miss_cnt;

  logic [TAG_B-1:0]  w_tag, w_vtag;
  logic [IDX_W-1:0]  w_idx;
  logic [SEL_W-1:0]  w_sel;
  logic              w_valid, w_dirty, w_hit;
  logic [LINE_W-1:0] w_line;
  logic [WORD_W-1:0] w_word;
  logic              w_idle, w_acc_hit, w_acc_miss;
  logic              w_wr_en, w_fill_en;
  logic [63:0]       w_req_la, w_vic_la;
  logic              w_unused;

  assign w_tag = cpu_addr_i[ADDR_W-1 -: TAG_B];
  assign w_idx = cpu_addr_i[OFF_W +: IDX_W];
  assign w_sel = cpu_addr_i[BYT_W +: SEL_W];

  assign w_req_la = line_addr(64'(w_tag), 64'(w_idx),
                              IDX_W, OFF_W);
  assign w_vic_la = line_addr(64'(w_vtag), 64'(w_idx),
                              IDX_W, OFF_W);

  assign w_unused = ^{cpu_addr_i[BYT_W-1:0],
                      w_req_la[63:ADDR_W],
                      w_vic_la[63:ADDR_W]};

  dcache_tag_data_array #(
    .LINE_W   (LINE_W),
    .WORD_W   (WORD_W),
    .NUM_SETS (NUM_SETS),
    .TAG_BITS (TAG_B),
    .IDX_BITS (IDX_W),
    .SEL_BITS (SEL_W)
  ) u_array (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (w_idx),
    .valid_o     (w_valid),
    .dirty_o     (w_dirty),
    .tag_o       (w_vtag),
    .line_o      (w_line),
    .wr_en_i     (w_wr_en),
    .wr_sel_i    (w_sel),
    .wr_data_i   (cpu_wdata_i),
    .fill_en_i   (w_fill_en),
    .fill_tag_i  (w_tag),
    .fill_line_i (mem_data_i)
  );

  assign w_hit      = w_valid && (w_vtag == w_tag);
  assign w_word     = w_line[w_sel*WORD_W +: WORD_W];
  assign w_idle     = (r_state == S_IDLE);
  assign w_acc_hit  = w_idle && cpu_req_i && w_hit;
  assign w_acc_miss = w_idle && cpu_req_i && !w_hit;
  assign w_wr_en    = w_acc_hit && cpu_we_i;
  assign w_fill_en  = (r_state == S_REFILL) && mem_ack_i;

  assign cpu_stall_o = !w_idle || w_acc_miss;
  assign cpu_rdata_o = (w_acc_hit && !cpu_we_i) ? w_word : '0;

  assign mem_enable_o = r_mem_en;
  assign mem_write_o  = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;
  assign hit_cnt_o    = r_hit_cnt;
  assign miss_cnt_o   = r_miss_cnt;

  always_comb begin
    w_state_n    = r_state;
    w_mem_en_n   = r_mem_en;
    w_mem_we_n   = r_mem_we;
    w_mem_addr_n = r_mem_addr;
    w_mem_data_n = r_mem_data;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc_miss) begin
          w_mem_en_n = 1'b1;
          if (w_valid && w_dirty) begin
            w_state_n    = S_WRITEBACK;
            w_mem_we_n   = 1'b1;
            w_mem_addr_n = w_vic_la[ADDR_W-1:0];
            w_mem_data_n = w_line;
          end else begin
            w_state_n    = S_REFILL;
            w_mem_we_n   = 1'b0;
            w_mem_addr_n = w_req_la[ADDR_W-1:0];
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_ack_i) begin
          w_state_n    = S_REFILL;
          w_mem_we_n   = 1'b0;
          w_mem_addr_n = w_req_la[ADDR_W-1:0];
        end
      end
      S_REFILL: begin
        if (mem_ack_i) begin
          w_state_n  = S_IDLE;
          w_mem_en_n = 1'b0;
          w_mem_we_n = 1'b0;
        end
      end
      default: begin
        w_state_n  = S_IDLE;
        w_mem_en_n = 1'b0;
        w_mem_we_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_state    <= w_state_n;
      r_mem_en   <= w_mem_en_n;
      r_mem_we   <= w_mem_we_n;
      r_mem_addr <= w_mem_addr_n;
      r_mem_data <= w_mem_data_n;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_acc_hit)
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      if (w_acc_miss)
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

endmodule
